// File: rtl/stream_fifo.sv
// Circular-buffer stream FIFO with first-word fall-through output and sticky error flags.
// Define STREAM_FIFO_ASSERT_EN to include simulation assertions on occupancy and handshakes.
module stream_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    input  logic [DATA_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         m_valid,
    output logic [DATA_WIDTH-1:0]        m_data,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;

    always_comb begin
        s_ready = (level < LVL_FULL);
        m_valid = (level != '0);
        m_data  = mem[rd_ptr];
        push    = s_valid && s_ready;
        pop     = m_valid && m_ready;
    end

    // Storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (s_valid && !s_ready) begin
                overflow <= 1'b1;
            end
            if (m_ready && !m_valid) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef STREAM_FIFO_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (level <= LVL_FULL)
                else $error("stream_fifo: level exceeds DEPTH");
            assert (!(push && level == LVL_FULL))
                else $error("stream_fifo: write while full");
            assert (!(pop && level == '0))
                else $error("stream_fifo: read while empty");
            assert (m_valid == (level != '0))
                else $error("stream_fifo: m_valid inconsistent with level");
        end
    end
`else
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: the driver queues expected words, a negedge monitor checks every pop.
module tb_stream_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [DW-1:0] exp_q [$];

    stream_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit accepted);
        s_valid = 1'b1;
        s_data  = d;
        if (accepted) exp_q.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    // Monitor: a pop happens on the next rising edge whenever m_valid && m_ready here.
    always @(negedge clk) begin
        if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got 0x%0h expected no word", m_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    failures++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", m_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step();
        check("rst_level", 32'(level), 0);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);
        rst = 1'b0;

        // Three pushes with the sink stalled, then an in-order drain.
        push_word(8'h11, 1'b1);
        check("fwft_m_valid", 32'(m_valid), 1);
        check("fwft_m_data", 32'(m_data), 32'h11);
        push_word(8'h22, 1'b1);
        push_word(8'h33, 1'b1);
        check("fill3_level", 32'(level), 3);
        m_ready = 1'b1;
        repeat (3) step();
        check("drain3_level", 32'(level), 0);

        // One more pop attempt on the empty FIFO.
        step();
        check("underflow_set", 32'(underflow), 1);
        check("underflow_level", 32'(level), 0);
        m_ready = 1'b0;
        repeat (2) step();
        check("underflow_sticky", 32'(underflow), 1);
        check("overflow_clear", 32'(overflow), 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_level", 32'(level), 0);
        check("rst2_overflow", 32'(overflow), 0);
        check("rst2_underflow", 32'(underflow), 0);
        check("rst2_s_ready", 32'(s_ready), 1);
        check("rst2_m_valid", 32'(m_valid), 0);

        // Fill to DEPTH, then an offered word that must be dropped.
        for (int i = 0; i < 4; i++) push_word(8'(i), 1'b1);
        check("full_level", 32'(level), 4);
        check("full_s_ready", 32'(s_ready), 0);
        push_word(8'hAA, 1'b0);
        check("overflow_set", 32'(overflow), 1);
        check("overflow_level", 32'(level), 4);
        m_ready = 1'b1;
        repeat (4) step();
        m_ready = 1'b0;
        check("drain4_level", 32'(level), 0);
        check("drain4_m_valid", 32'(m_valid), 0);
        check("overflow_sticky", 32'(overflow), 1);

        // Steady state at level 2 with simultaneous push and pop across pointer wrap.
        push_word(8'h50, 1'b1);
        push_word(8'h51, 1'b1);
        check("stream_pre_level", 32'(level), 2);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'h60 + 8'(i);
            exp_q.push_back(s_data);
            step();
            check("stream_level", 32'(level), 2);
        end
        s_valid = 1'b0;
        repeat (2) step();
        m_ready = 1'b0;
        check("stream_drain_level", 32'(level), 0);

        // Reset while holding three words; they must be discarded.
        push_word(8'h70, 1'b1);
        push_word(8'h71, 1'b1);
        push_word(8'h72, 1'b1);
        check("mid_pre_level", 32'(level), 3);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_m_valid", 32'(m_valid), 0);
        push_word(8'h80, 1'b1);
        push_word(8'h81, 1'b1);
        check("post_rst_level", 32'(level), 2);
        m_ready = 1'b1;
        repeat (2) step();
        m_ready = 1'b0;
        check("post_rst_drain", 32'(level), 0);
        step();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width in bits; legal range is at least 1.
REQ-002 Parameter DEPTH, default 4, number of storage entries; legal range is at least 2; it need not be a power of two.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 s_valid  input  1  upstream word offered.
REQ-006 s_data  input  DATA_WIDTH  upstream word.
REQ-007 s_ready  output  1  FIFO can accept a word.
REQ-008 m_valid  output  1  head word available.
REQ-009 m_data  output  DATA_WIDTH  head word.
REQ-010 m_ready  input  1  downstream consumes the head word.
REQ-011 level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: a push was attempted while full.
REQ-013 underflow  output  1  sticky flag: a pop was attempted while empty.

Function
REQ-014 Storage SHALL be a circular buffer with write and read pointers that wrap from DEPTH-1 to 0.
REQ-015 s_ready SHALL be combinational and equal to (level < DEPTH); it has no same-cycle dependency on m_ready.
REQ-016 m_valid SHALL be combinational and equal to (level != 0).
REQ-017 m_data SHALL combinationally present the oldest stored word (first-word fall-through, zero read latency); its value when m_valid=0 is don't-care.
REQ-018 A push SHALL occur on a rising edge where s_valid && s_ready; the word is written at the write pointer and the pointer advances.
REQ-019 A pop SHALL occur on a rising edge where m_valid && m_ready; the read pointer advances.
REQ-020 A simultaneous push and pop SHALL both take effect, and level SHALL remain unchanged.
REQ-021 level SHALL change by +1 on a push only, by -1 on a pop only, and by 0 otherwise; it never exceeds DEPTH or goes below 0.
REQ-022 A word pushed at edge N SHALL be visible on m_data with m_valid=1 after edge N when the FIFO was empty.
REQ-023 Data SHALL leave the FIFO in strict push order with no loss or duplication.
REQ-024 When full, s_valid SHALL NOT write; the offered word is dropped from the FIFO's point of view, and contents stay intact.
REQ-025 overflow SHALL be set on the edge where s_valid && !s_ready, and SHALL hold until reset.
REQ-026 underflow SHALL be set on the edge where m_ready && !m_valid, and SHALL hold until reset.
REQ-027 A rejected push or pop SHALL NOT move the pointers or change level.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL clear the pointers, level, overflow and underflow to 0; s_ready becomes 1 and m_valid becomes 0.
REQ-029 Reset SHALL take precedence over any push or pop in the same cycle, and any stored words are discarded.
REQ-030 Storage contents SHALL NOT require a reset.

Configuration
REQ-031 When macro STREAM_FIFO_ASSERT_EN is defined, the block SHALL include simulation assertions checking level <= DEPTH, that no write occurs while full, that no read occurs while empty, and that m_valid == (level != 0).
REQ-032 When STREAM_FIFO_ASSERT_EN is undefined, no assertion code SHALL be present, and functional behaviour SHALL be identical.

Verification
REQ-033 Push 0x11, 0x22, 0x33 with m_ready=0 -> level=3, then pop three times -> m_data reads 0x11, 0x22, 0x33 in order, and level returns to 0.
REQ-034 After draining to empty, assert m_ready for 1 cycle -> underflow=1 after that edge, level stays 0, and underflow stays 1 until rst.
REQ-035 Apply rst=1 for one edge -> level=0, overflow=0, underflow=0, s_ready=1, m_valid=0.
REQ-036 Hold m_ready=0 and push 0x00..0x03 -> level=4 and s_ready=0; then push 0xAA -> overflow=1 and level stays 4; then drain with m_ready=1 -> reads 0x00..0x03, and 0xAA never appears.
REQ-037 Hold s_valid=1 and m_ready=1 continuously with level=2 -> level stays 2 each cycle, and output order matches input order across pointer wrap-around.
REQ-038 Assert rst mid-stream with level=3 -> at the next edge level=0, m_valid=0, and subsequent pushes read back correctly.
